// File: rtl/pc_sequencer_if.sv
// Vector-fetch bus between the PC sequencer and the vector memory.
// The sequencer raises vec_rd with a stable vec_addr until memory
// answers with vec_valid/vec_data (any number of cycles later).
interface pc_sequencer_if #(
    parameter int AW = 8
);
    logic          vec_rd;
    logic [AW-1:0] vec_addr;
    logic [AW-1:0] vec_data;
    logic          vec_valid;

    modport master (
        output vec_rd,
        output vec_addr,
        input  vec_data,
        input  vec_valid
    );

    modport slave (
        input  vec_rd,
        input  vec_addr,
        output vec_data,
        output vec_valid
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: boots from vector M[0], steps the PC,
// applies branch/return redirects and stalls, and takes prioritised
// edge-triggered interrupts through vectors M[1+k].
module pc_sequencer #(
    parameter int AW   = 8,
    parameter int NIRQ = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sys_rst_req,
    input  logic [NIRQ-1:0] irq,
    input  logic            irq_en,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [AW-1:0]   branch_target,
    input  logic            ret_taken,
    input  logic [AW-1:0]   ret_addr,
    pc_sequencer_if.master  vec,
    output logic [AW-1:0]   pc,
    output logic            pc_valid,
    output logic            intr_ack,
    output logic [2:0]      intr_id,
    output logic [AW-1:0]   save_pc
);

    typedef enum logic [1:0] {
        RST_FETCH,
        IRQ_FETCH,
        RUN
    } state_t;

    state_t          state;
    logic [NIRQ-1:0] irq_q;
    logic [NIRQ-1:0] irq_pend;
    logic [NIRQ-1:0] irq_rise;
    logic [NIRQ-1:0] accept_mask;
    logic [AW-1:0]   seq_next;
    logic [2:0]      pend_idx;
    logic            accept;

    // Lowest set bit wins: irq[0] has the highest priority.
    function automatic logic [2:0] lowest_pending(input logic [NIRQ-1:0] p);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (p[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Next sequential PC and interrupt-accept decision for this cycle.
    always_comb begin
        irq_rise    = irq & ~irq_q;
        pend_idx    = lowest_pending(irq_pend);
        if (ret_taken)
            seq_next = ret_addr;
        else if (branch_taken)
            seq_next = branch_target;
        else
            seq_next = pc + AW'(1);
        accept      = (state == RUN) && irq_en && !stall && !sys_rst_req && (|irq_pend);
        accept_mask = accept ? (NIRQ'(1) << pend_idx) : '0;
    end

    // Sequencer FSM with registered bus and status outputs. A new irq edge
    // is ORed in after the accept clear, so an edge coincident with the
    // accept of the same line stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RST_FETCH;
            pc           <= '0;
            pc_valid     <= 1'b0;
            irq_q        <= '0;
            irq_pend     <= '0;
            intr_ack     <= 1'b0;
            intr_id      <= 3'd0;
            save_pc      <= '0;
            vec.vec_rd   <= 1'b1;
            vec.vec_addr <= '0;
        end else begin
            irq_q    <= irq;
            irq_pend <= (irq_pend & ~accept_mask) | irq_rise;
            intr_ack <= 1'b0;
            if (sys_rst_req) begin
                // Architectural reset wins everywhere, aborting any vector fetch.
                state        <= RST_FETCH;
                pc_valid     <= 1'b0;
                vec.vec_rd   <= 1'b1;
                vec.vec_addr <= '0;
            end else begin
                case (state)
                    RST_FETCH, IRQ_FETCH: begin
                        if (vec.vec_valid) begin
                            pc         <= vec.vec_data;
                            state      <= RUN;
                            pc_valid   <= 1'b1;
                            vec.vec_rd <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            // Push the redirect/increment this cycle would have
                            // produced so the return lands where flow was going.
                            state        <= IRQ_FETCH;
                            pc_valid     <= 1'b0;
                            vec.vec_rd   <= 1'b1;
                            vec.vec_addr <= AW'(pend_idx) + AW'(1);
                            intr_ack     <= 1'b1;
                            intr_id      <= pend_idx;
                            save_pc      <= seq_next;
                        end else if (!stall) begin
                            pc <= seq_next;
                        end
                    end
                    default: begin
                        state        <= RST_FETCH;
                        pc_valid     <= 1'b0;
                        vec.vec_rd   <= 1'b1;
                        vec.vec_addr <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios followed by random traffic,
// checked every cycle against a behavioural model of the sequencer.
module tb_pc_sequencer;
    localparam int AW   = 8;
    localparam int NIRQ = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            sys_rst_req;
    logic [NIRQ-1:0] irq;
    logic            irq_en;
    logic            stall;
    logic            branch_taken;
    logic [AW-1:0]   branch_target;
    logic            ret_taken;
    logic [AW-1:0]   ret_addr;
    logic [AW-1:0]   pc;
    logic            pc_valid;
    logic            intr_ack;
    logic [2:0]      intr_id;
    logic [AW-1:0]   save_pc;

    pc_sequencer_if #(.AW(AW)) vbus ();

    pc_sequencer #(.AW(AW), .NIRQ(NIRQ)) dut (
        .clk           (clk),
        .rst           (rst),
        .sys_rst_req   (sys_rst_req),
        .irq           (irq),
        .irq_en        (irq_en),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .ret_taken     (ret_taken),
        .ret_addr      (ret_addr),
        .vec           (vbus),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .intr_ack      (intr_ack),
        .intr_id       (intr_id),
        .save_pc       (save_pc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Vector memory with configurable answer latency.
    logic [AW-1:0] mem [16];
    int            mem_lat;
    int            mem_cnt;
    logic          last_rd;
    logic [AW-1:0] last_addr;
    bit            spurious_en;

    // Behavioural model state.
    bit            m_run;
    int            m_vaddr;
    int            m_pc;
    bit [NIRQ-1:0] m_pend;
    bit [NIRQ-1:0] m_irq_last;
    bit            m_ack;
    int            m_id;
    int            m_save;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run      = 1'b0;
        m_vaddr    = 0;
        m_pc       = 0;
        m_pend     = '0;
        m_irq_last = '0;
        m_ack      = 1'b0;
        m_id       = 0;
        m_save     = 0;
    endtask

    // One clock of architectural behaviour, from the inputs now applied.
    task automatic model_step();
        int target;
        int k;
        m_ack = 1'b0;
        if (ret_taken)         target = int'(ret_addr);
        else if (branch_taken) target = int'(branch_target);
        else                   target = (m_pc + 1) % (1 << AW);
        if (sys_rst_req) begin
            m_run   = 1'b0;
            m_vaddr = 0;
        end else if (!m_run) begin
            if (vbus.vec_valid) begin
                m_pc  = int'(vbus.vec_data);
                m_run = 1'b1;
            end
        end else if (irq_en && !stall && m_pend != 0) begin
            k = 0;
            while (!m_pend[k]) k++;
            m_ack     = 1'b1;
            m_id      = k;
            m_save    = target;
            m_pend[k] = 1'b0;
            m_run     = 1'b0;
            m_vaddr   = k + 1;
        end else if (!stall) begin
            m_pc = target;
        end
        m_pend     = m_pend | (irq & ~m_irq_last);
        m_irq_last = irq;
    endtask

    // Memory answers a stable request after mem_lat waiting cycles.
    task automatic mem_drive();
        if (vbus.vec_rd) begin
            if (!last_rd || vbus.vec_addr != last_addr) mem_cnt = 0;
            if (mem_cnt >= mem_lat) begin
                vbus.vec_valid = 1'b1;
                vbus.vec_data  = mem[vbus.vec_addr[3:0]];
                mem_cnt        = 0;
            end else begin
                vbus.vec_valid = 1'b0;
                vbus.vec_data  = AW'($urandom);
                mem_cnt++;
            end
        end else begin
            vbus.vec_valid = spurious_en && ($urandom_range(0, 3) == 0);
            vbus.vec_data  = AW'($urandom);
        end
        last_rd   = vbus.vec_rd;
        last_addr = vbus.vec_addr;
    endtask

    task automatic cycle();
        mem_drive();
        model_step();
        @(posedge clk);
        #1;
        chk("pc", 32'(pc), 32'(m_pc));
        chk("pc_valid", 32'(pc_valid), 32'(m_run));
        chk("vec_rd", 32'(vbus.vec_rd), 32'(!m_run));
        if (!m_run) chk("vec_addr", 32'(vbus.vec_addr), 32'(m_vaddr));
        chk("intr_ack", 32'(intr_ack), 32'(m_ack));
        if (m_ack) begin
            chk("intr_id", 32'(intr_id), 32'(m_id));
            chk("save_pc", 32'(save_pc), 32'(m_save));
        end
    endtask

    task automatic run_until_valid(input int max);
        int n;
        n = 0;
        while (!pc_valid && n < max) begin
            cycle();
            n++;
        end
        chk("fetch_timeout", 32'(pc_valid), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        sys_rst_req    = 1'b0;
        irq            = '0;
        irq_en         = 1'b0;
        stall          = 1'b0;
        branch_taken   = 1'b0;
        branch_target  = '0;
        ret_taken      = 1'b0;
        ret_addr       = '0;
        vbus.vec_valid = 1'b0;
        vbus.vec_data  = '0;
        for (int i = 0; i < 16; i++) mem[i] = AW'(8'h90 + i * 8);
        mem[0]      = 8'h20;
        mem_lat     = 3;
        mem_cnt     = 0;
        last_rd     = 1'b0;
        last_addr   = '0;
        spurious_en = 1'b0;
        model_reset();

        // Reset values held while rst is asserted.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_pc_valid", 32'(pc_valid), 32'd0);
        chk("rst_intr_ack", 32'(intr_ack), 32'd0);
        chk("rst_intr_id", 32'(intr_id), 32'd0);
        chk("rst_save_pc", 32'(save_pc), 32'd0);
        chk("rst_vec_rd", 32'(vbus.vec_rd), 32'd1);
        chk("rst_vec_addr", 32'(vbus.vec_addr), 32'd0);
        rst = 1'b0;

        // Boot from M[0]=0x20 after a 3-cycle memory latency, then count.
        run_until_valid(20);
        chk("boot_pc", 32'(pc), 32'h20);
        cycle();
        chk("boot_pc_inc1", 32'(pc), 32'h21);
        cycle();
        chk("boot_pc_inc2", 32'(pc), 32'h22);

        // Two simultaneous edges: lower index first, the other stays pending.
        irq_en        = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 8'h2F;
        cycle();
        branch_taken  = 1'b0;
        irq           = 4'b0110;
        cycle();
        chk("prio_pc_before", 32'(pc), 32'h30);
        cycle();
        chk("prio_ack", 32'(intr_ack), 32'd1);
        chk("prio_id", 32'(intr_id), 32'd1);
        chk("prio_save", 32'(save_pc), 32'h31);
        chk("prio_vaddr", 32'(vbus.vec_addr), 32'd2);
        run_until_valid(20);
        chk("prio_isr_pc", 32'(pc), 32'(mem[2]));
        ret_taken = 1'b1;
        ret_addr  = 8'h31;
        cycle();
        ret_taken = 1'b0;
        chk("second_ack", 32'(intr_ack), 32'd1);
        chk("second_id", 32'(intr_id), 32'd2);
        chk("second_save", 32'(save_pc), 32'h31);
        chk("second_vaddr", 32'(vbus.vec_addr), 32'd3);
        irq = '0;
        run_until_valid(20);

        // Branch coincident with accept: save_pc takes the branch target.
        irq_en        = 1'b0;
        irq           = 4'b0001;
        cycle();
        branch_taken  = 1'b1;
        branch_target = 8'h40;
        cycle();
        chk("br_pc_40", 32'(pc), 32'h40);
        chk("br_no_ack", 32'(intr_ack), 32'd0);
        irq_en        = 1'b1;
        branch_target = 8'h80;
        cycle();
        branch_taken  = 1'b0;
        chk("br_ack", 32'(intr_ack), 32'd1);
        chk("br_id", 32'(intr_id), 32'd0);
        chk("br_save", 32'(save_pc), 32'h80);
        chk("br_vaddr", 32'(vbus.vec_addr), 32'd1);
        irq = '0;
        run_until_valid(20);

        // PC wrap from 0xFF to 0x00.
        irq_en        = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 8'hFF;
        cycle();
        branch_taken  = 1'b0;
        chk("wrap_ff", 32'(pc), 32'hFF);
        cycle();
        chk("wrap_00", 32'(pc), 32'h00);

        // Architectural reset aborts an interrupt vector fetch.
        irq_en  = 1'b1;
        mem_lat = 5;
        irq     = 4'b1000;
        cycle();
        cycle();
        chk("abort_ack", 32'(intr_ack), 32'd1);
        chk("abort_vaddr_irq", 32'(vbus.vec_addr), 32'd4);
        cycle();
        cycle();
        sys_rst_req = 1'b1;
        cycle();
        sys_rst_req = 1'b0;
        chk("abort_vaddr_rst", 32'(vbus.vec_addr), 32'd0);
        chk("abort_no_ack", 32'(intr_ack), 32'd0);
        run_until_valid(30);
        chk("abort_pc_m0", 32'(pc), 32'h20);
        mem_lat = 2;

        // Masked edge is held; stalled branch is dropped.
        irq    = '0;
        irq_en = 1'b0;
        cycle();
        irq           = 4'b1000;
        stall         = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 8'h55;
        cycle();
        chk("stall_pc_held", 32'(pc), 32'h21);
        chk("stall_no_ack", 32'(intr_ack), 32'd0);
        branch_taken = 1'b0;
        stall        = 1'b0;
        irq_en       = 1'b1;
        cycle();
        chk("unmask_ack", 32'(intr_ack), 32'd1);
        chk("unmask_id", 32'(intr_id), 32'd3);
        chk("unmask_save", 32'(save_pc), 32'h22);
        irq = '0;
        run_until_valid(20);

        // Asynchronous hardware reset in the middle of RUN.
        cycle();
        #3;
        rst = 1'b1;
        #1;
        chk("async_pc", 32'(pc), 32'd0);
        chk("async_pc_valid", 32'(pc_valid), 32'd0);
        chk("async_vec_rd", 32'(vbus.vec_rd), 32'd1);
        chk("async_vec_addr", 32'(vbus.vec_addr), 32'd0);
        model_reset();
        last_rd = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_until_valid(20);

        // Random traffic against the model.
        spurious_en = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if (m_run || vbus.vec_rd == 1'b0) mem_lat = $urandom_range(0, 4);
            sys_rst_req   = ($urandom_range(0, 99) == 0);
            irq_en        = ($urandom_range(0, 4) != 0);
            stall         = ($urandom_range(0, 4) == 0);
            branch_taken  = ($urandom_range(0, 9) == 0);
            branch_target = AW'($urandom);
            ret_taken     = ($urandom_range(0, 9) == 0);
            ret_addr      = AW'($urandom);
            for (int b = 0; b < NIRQ; b++) begin
                if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
            end
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter AW, default 8, PC and vector-bus address width.
REQ-002 Parameter NIRQ, default 4, number of interrupt request lines (1..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  hardware reset, asynchronous, active-high.
REQ-005 sys_rst_req  input  1  architectural reset request; reloads PC from vector M[0].
REQ-006 irq  input  NIRQ  level interrupt lines; bit 0 highest priority.
REQ-007 irq_en  input  1  global interrupt enable.
REQ-008 stall  input  1  hold PC; no sequencing this cycle.
REQ-009 branch_taken  input  1  load branch_target.
REQ-010 branch_target  input  AW  branch destination.
REQ-011 ret_taken  input  1  load ret_addr (RET/RTI at write-back).
REQ-012 ret_addr  input  AW  return destination.
REQ-013 vec_rd  output  1  vector read request to memory.
REQ-014 vec_addr  output  AW  vector address; 0 for reset, 1+k for interrupt k.
REQ-015 vec_data  input  AW  vector value returned by memory.
REQ-016 vec_valid  input  1  vec_data valid this cycle; arbitrary latency.
REQ-017 pc  output  AW  current fetch address.
REQ-018 pc_valid  output  1  pc is a valid fetch address (state RUN).
REQ-019 intr_ack  output  1  one-cycle pulse when an interrupt is accepted.
REQ-020 intr_id  output  3  index of accepted interrupt, valid with intr_ack.
REQ-021 save_pc  output  AW  PC to push on accept, valid with intr_ack.

Function
REQ-022 FSM states RST_FETCH, IRQ_FETCH, RUN shall be implemented.
REQ-023 RST_FETCH/IRQ_FETCH: vec_rd=1, vec_addr stable, pc held, pc_valid=0; on vec_valid, pc<=vec_data and next state RUN.
REQ-024 RUN priority per cycle: sys_rst_req > interrupt accept > stall > ret_taken > branch_taken > pc+1.
REQ-025 sys_rst_req in any state: next state RST_FETCH, vec_addr=0; aborts an in-progress IRQ_FETCH without intr_ack.
REQ-026 Pending register irq_pend[NIRQ] shall set on a 0->1 edge of irq[k] and hold until accepted; edges during fetch states or while irq_en=0 are kept pending.
REQ-027 Accept occurs in RUN when irq_en=1, stall=0, sys_rst_req=0 and irq_pend nonzero; lowest pending index k is chosen.
REQ-028 On accept: intr_ack=1, intr_id=k, irq_pend[k] cleared, next state IRQ_FETCH with vec_addr=1+k.
REQ-029 save_pc on accept shall equal the PC that would otherwise have been loaded this cycle (ret_addr, branch_target or pc+1) so no redirect is lost.
REQ-030 stall in RUN holds pc; branch_taken/ret_taken in a stalled cycle are dropped.
REQ-031 pc+1 wraps modulo 2^AW (max -> 0).
REQ-032 vec_data is consumed only on the cycle vec_valid=1 in a fetch state; vec_valid in RUN is ignored.
REQ-033 An irq edge coincident with accept of the same index shall remain pending.

Reset
REQ-034 While rst=1: state RST_FETCH, pc=0, irq_pend=0, intr_ack=0, intr_id=0, save_pc=0, pc_valid=0.
REQ-035 After rst release the block fetches M[0] with no further stimulus (vec_rd=1, vec_addr=0).
REQ-036 rst asserted mid-fetch or mid-RUN shall abort immediately, asynchronously.

Verification
REQ-037 rst release, vec_valid after 3 cycles with vec_data=0x20 -> pc=0x20, pc_valid=1, then 0x21, 0x22.
REQ-038 RUN pc=0x30, irq[2] and irq[1] rise same cycle -> intr_ack, intr_id=1, save_pc=0x31, vec_addr=2; after return irq[2] accepted, vec_addr=3.
REQ-039 pc=0x40, branch_taken target 0x80 coincident with accept of irq[0] -> save_pc=0x80, vec_addr=1.
REQ-040 pc=0xFF, AW=8, no events -> pc=0x00 next cycle.
REQ-041 IRQ_FETCH in progress, sys_rst_req=1 -> vec_addr=0, IRQ vector discarded, pc loads M[0] value.
REQ-042 irq_en=0 with irq[3] edge, stall=1 with branch_taken -> pc held, no ack; irq_en=1, stall=0 -> accept intr_id=3.
